fetch_queue: RTL and testbench

Instruction fetch buffer sitting directly downstream of the `pc` register in the pipelined MIPS datapath. It issues the current PC to instruction memory with a req/gnt handshake and drives the `pc` enable so the PC advances only when a fetch is accepted. It collects in-order memory responses into a small {PC, instruction} FIFO that feeds the decode stage. On a branch or jump redirect it flushes the FIFO and discards any in-flight response.

---
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue.sv | 97 +++++++++
 tb/tb_fetch_queue.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Instruction-memory request/response bus plus the decode-side FIFO head port.
// Handshakes: im_req/im_gnt transfer the request in the cycle both are 1; im_rvalid
// returns one in-order response per accepted request; ifq_valid/id_ready pop the head
// in the cycle both are 1. im_req never depends on im_gnt.
interface fetch_queue_if;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_gnt;
   logic        im_rvalid;
   logic [31:0] im_rdata;
   logic        ifq_valid;
   logic [31:0] ifq_pc;
   logic [31:0] ifq_instr;
   logic        id_ready;

   modport master (
      output im_req, im_addr, ifq_valid, ifq_pc, ifq_instr,
      input  im_gnt, im_rvalid, im_rdata, id_ready
   );

   modport slave (
      input  im_req, im_addr, ifq_valid, ifq_pc, ifq_instr,
      output im_gnt, im_rvalid, im_rdata, id_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// Fetch buffer between the pc register and decode: one outstanding instruction-memory
// request, responses collected into a {pc, instr} FIFO, flushed on redirect.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [31:0]            pcAddr,
   output logic                   pc_en,
   input  logic                   flush,
   fetch_queue_if.master          bus,
   output logic [1:0]             state,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t        st, st_next;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   cnt;
   logic [31:0]   req_pc;
   logic [31:0]   mem_pc    [DEPTH];
   logic [31:0]   mem_instr [DEPTH];
   logic          valid, req, grant, push, pop;

   // A request reserves its FIFO slot up front, so the WAIT push can never overflow.
   assign req   = (st == IDLE) && (cnt < FULL) && !flush && !Reset;
   assign grant = req && bus.im_gnt;
   assign valid = !Reset && (cnt != '0);
   assign pop   = valid && bus.id_ready && !flush;
   assign push  = (st == WAIT) && bus.im_rvalid && !flush;
   assign pc_en = grant || flush;

   assign bus.im_req    = req;
   assign bus.im_addr   = pcAddr;
   assign bus.ifq_valid = valid;
   assign bus.ifq_pc    = mem_pc[rd_ptr];
   assign bus.ifq_instr = mem_instr[rd_ptr];
   assign state         = st;
   assign count         = cnt;

   always_comb begin
      st_next = st;
      case (st)
         IDLE:    if (grant) st_next = WAIT;
         WAIT: begin
            if (bus.im_rvalid)  st_next = IDLE;
            else if (flush)     st_next = DISCARD;
         end
         DISCARD: if (bus.im_rvalid) st_next = IDLE;
         default: st_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) st <= IDLE;
      else       st <= st_next;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         req_pc <= '0;
      end else if (flush) begin
         cnt    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (grant) req_pc <= pcAddr;
         if (push)  wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      cnt <= cnt + 1'b1;
         else if (pop && !push) cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc[i]    <= RESET_PC;
            mem_instr[i] <= '0;
         end
      end else if (push) begin
         mem_pc[wr_ptr]    <= req_pc;
         mem_instr[wr_ptr] <= bus.im_rdata;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic against a queue-based
// model of the fetch buffer, with a small pc register and memory responder around it.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] pcAddr = RESET_PC;
  logic        pc_en;
  logic        flush = 1'b0;
  logic [1:0]  state;
  logic [2:0]  count;

  fetch_queue_if bus();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .Clk(Clk), .Reset(Reset), .pcAddr(pcAddr), .pc_en(pc_en), .flush(flush),
    .bus(bus.master), .state(state), .count(count)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // reference model: queue of {pc, instr} plus the single in-flight fetch
  logic [63:0] exp_q[$];
  bit          busy = 0;
  bit          kept = 0;
  logic [31:0] busy_pc = '0;
  logic [31:0] popped[$];
  int          grants = 0;

  // environment: memory responder and redirect target
  bit          mem_busy = 0;
  int          mem_wait = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] target = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic [63:0] head;
    bit e_valid, e_req, e_grant, env_grant, env_pcen, resp;
    bus.im_rvalid = 1'b0;
    bus.im_rdata  = $urandom;
    if (mem_busy) begin
      if (mem_wait == 0) bus.im_rvalid = 1'b1;
      else mem_wait--;
    end
    @(negedge Clk);
    e_valid = (exp_q.size() != 0) && !Reset;
    e_req   = !Reset && !busy && (exp_q.size() < DEPTH) && !flush;
    e_grant = e_req && bus.im_gnt;
    check("im_req", 64'(bus.im_req), 64'(e_req));
    check("pc_en", 64'(pc_en), 64'(e_grant || flush));
    check("ifq_valid", 64'(bus.ifq_valid), 64'(e_valid));
    check("im_addr", 64'(bus.im_addr), 64'(pcAddr));
    if (!Reset) begin
      check("count", 64'(count), 64'(exp_q.size()));
      check("state", 64'(state), !busy ? 64'd0 : (kept ? 64'd1 : 64'd2));
      if (e_valid) begin
        head = exp_q[0];
        check("ifq_pc", 64'(bus.ifq_pc), 64'(head[63:32]));
        check("ifq_instr", 64'(bus.ifq_instr), 64'(head[31:0]));
      end
    end
    if (Reset) begin
      exp_q.delete();
      busy = 0;
    end else if (flush) begin
      exp_q.delete();
      if (busy && bus.im_rvalid) busy = 0;
      else if (busy) kept = 0;
    end else begin
      if (e_valid && bus.id_ready) begin
        head = exp_q.pop_front();
        popped.push_back(head[63:32]);
      end
      if (busy && bus.im_rvalid) begin
        if (kept) exp_q.push_back({busy_pc, bus.im_rdata});
        busy = 0;
      end
      if (e_grant) begin
        busy = 1; kept = 1; busy_pc = pcAddr; grants++;
      end
    end
    env_grant = bus.im_req && bus.im_gnt;
    env_pcen  = pc_en;
    resp      = bus.im_rvalid;
    @(posedge Clk);
    #1;
    if (Reset) begin
      pcAddr   = RESET_PC;
      mem_busy = 0;
    end else begin
      if (env_pcen) pcAddr = flush ? target : pcAddr + 32'd4;
      if (resp) mem_busy = 0;
      if (env_grant) begin
        mem_busy = 1;
        mem_wait = int'($urandom_range(lat_max, lat_min)) - 1;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    flush = 1'b0;
    ticks(2);
    Reset = 1'b0;
    popped.delete();
    grants = 0;
  endtask

  initial begin
    bus.im_gnt    = 1'b0;
    bus.im_rvalid = 1'b0;
    bus.im_rdata  = '0;
    bus.id_ready  = 1'b0;

    // reset values
    do_reset();
    check("rst_ifq_pc", 64'(bus.ifq_pc), 64'(RESET_PC));
    check("rst_ifq_instr", 64'(bus.ifq_instr), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);

    // streaming with zero-wait memory
    bus.im_gnt = 1'b1; bus.id_ready = 1'b1; lat_min = 1; lat_max = 1;
    ticks(20);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] v;
      v = (i < popped.size()) ? popped[i] : 32'hffff_ffff;
      check("stream_pc", 64'(v), 64'(RESET_PC + 32'(4 * i)));
    end
    check("stream_rate", 64'(popped.size()), 64'd9);

    // fill with decode stalled, then one pop frees one slot
    do_reset();
    bus.im_gnt = 1'b1; bus.id_ready = 1'b0;
    ticks(12);
    check("fill_count", 64'(count), 64'(DEPTH));
    check("fill_req", 64'(bus.im_req), 64'd0);
    check("fill_pc_en", 64'(pc_en), 64'd0);
    check("fill_grants", 64'(grants), 64'(DEPTH));
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
    check("fill_pop_pc", popped.size() > 0 ? 64'(popped[0]) : 64'hdead, 64'(RESET_PC));
    ticks(6);
    check("fill_regrant", 64'(grants), 64'(DEPTH + 1));
    check("fill_count2", 64'(count), 64'(DEPTH));

    // flush in WAIT, response 3 cycles later is discarded
    do_reset();
    bus.im_gnt = 1'b1; bus.id_ready = 1'b0; lat_min = 1; lat_max = 1;
    ticks(4);
    lat_min = 4; lat_max = 4;
    tick();
    bus.im_gnt = 1'b0; flush = 1'b1; target = 32'h0000_4a40;
    tick();
    flush = 1'b0;
    check("fl_state", 64'(state), 64'd2);
    check("fl_valid", 64'(bus.ifq_valid), 64'd0);
    ticks(2);
    check("fl_state_hold", 64'(state), 64'd2);
    tick();
    check("fl_late_rv", 64'(bus.im_rvalid), 64'd1);
    check("fl_idle", 64'(state), 64'd0);
    check("fl_no_push", 64'(count), 64'd0);
    bus.im_gnt = 1'b1; lat_min = 1; lat_max = 1;
    ticks(3);
    check("fl_tgt_valid", 64'(bus.ifq_valid), 64'd1);
    check("fl_tgt_pc", 64'(bus.ifq_pc), 64'(target));

    // flush coinciding with the response
    do_reset();
    bus.im_gnt = 1'b1; bus.id_ready = 1'b0; lat_min = 1; lat_max = 1;
    ticks(4);
    lat_min = 2; lat_max = 2;
    tick();
    bus.im_gnt = 1'b0;
    tick();
    flush = 1'b1; target = 32'h0000_5000;
    tick();
    flush = 1'b0;
    check("flrv_rv", 64'(bus.im_rvalid), 64'd1);
    check("flrv_state", 64'(state), 64'd0);
    check("flrv_count", 64'(count), 64'd0);

    // DEPTH-1 entries, pop and push together, then stream across the pointer wrap
    do_reset();
    bus.im_gnt = 1'b1; bus.id_ready = 1'b0; lat_min = 1; lat_max = 1;
    ticks(6);
    check("wrap_pre", 64'(count), 64'(DEPTH - 1));
    tick();
    bus.id_ready = 1'b1;
    tick();
    check("wrap_same", 64'(count), 64'(DEPTH - 1));
    ticks(16);

    // reset while waiting for a response
    do_reset();
    bus.im_gnt = 1'b1; lat_min = 3; lat_max = 3;
    tick();
    Reset = 1'b1;
    tick();
    check("rstw_state", 64'(state), 64'd0);
    check("rstw_valid", 64'(bus.ifq_valid), 64'd0);
    check("rstw_pc", 64'(bus.ifq_pc), 64'(RESET_PC));
    check("rstw_req", 64'(bus.im_req), 64'd0);
    tick();
    Reset = 1'b0;
    popped.delete();

    // random traffic
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      bus.im_gnt   = ($urandom_range(0, 3) != 0);
      bus.id_ready = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      target       = {$urandom_range(0, 32'h3fff), 2'b00};
      Reset        = ($urandom_range(0, 199) == 0);
      tick();
    end
    Reset = 1'b0; flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
